// File: rtl/irda_rz_bit_decoder.sv
// irda_rz_bit_decoder
//   Oversampled return-to-zero bit decoder for the IrDA fast receive path.
//   Each bit occupies OSR consecutive samples (one per clk while active).
//   A pulse of at least MIN_PULSE consecutive high samples inside a window
//   decodes as bit 0; a window without such a pulse decodes as bit 1.
//
// Parameters
//   OSR       samples per bit window (2..16)
//   CNT_W     width of the phase and run counters, must hold OSR
//   MIN_PULSE consecutive high samples that register a pulse (1..OSR)
//
// Ports
//   clk          sample clock
//   wb_rst_i     asynchronous active-high reset
//   fast_enable  fast-mode global enable
//   mir_mode     decoder selected
//   tx_select    transmitter owns the link (decoder idle when 1)
//   rx_i         synchronised receive line, active-high pulse
//   bit_o        decoded bit, updated at each window close, held otherwise
//   bit_valid_o  one-cycle strobe following each window close
//   err_o        window was high on every sample (qualified by bit_valid_o)
//
// Optional build macro
//   IRDA_RZ_RESYNC_EN  rising edges on rx_i re-align the window phase
//                      (early edge at the last phase starts a new window,
//                      late edge at phase 1 stretches the window by one).

module irda_rz_bit_decoder #(
  parameter int OSR       = 4,
  parameter int CNT_W     = 4,
  parameter int MIN_PULSE = 1
) (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic fast_enable,
  input  logic mir_mode,
  input  logic tx_select,
  input  logic rx_i,
  output logic bit_o,
  output logic bit_valid_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] OSR_C      = CNT_W'(OSR);
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_PULSE);

  logic [CNT_W-1:0] phase_r;
  logic [CNT_W-1:0] run_r;
  logic             pulse_seen_r;
  logic             all_high_r;

  logic             active_s;
  logic [CNT_W-1:0] run_next_s;
  logic             qual_s;
  logic             close_s;
  logic [CNT_W-1:0] phase_next_s;
  logic             pulse_next_s;
  logic             all_high_next_s;
  logic             close_bit_s;
  logic             close_err_s;

`ifdef IRDA_RZ_RESYNC_EN
  logic             rx_d_r;
  logic             edge_s;
`endif

  // Next-state computation for the run counter, pulse qualification and window phase.
  always_comb begin
    active_s = mir_mode & ~tx_select & fast_enable;

    // Saturating run of consecutive high samples; survives window boundaries.
    if (rx_i == 1'b1) begin
      if (run_r >= OSR_C) begin
        run_next_s = OSR_C;
      end else begin
        run_next_s = run_r + ONE_C;
      end
    end else begin
      run_next_s = ZERO_C;
    end

    // Qualify only on the transition into MIN_PULSE, so a run that is already
    // saturated at MIN_PULSE (MIN_PULSE == OSR) does not re-qualify.
    qual_s = rx_i & (run_next_s == MIN_C) & (run_r != MIN_C);

    close_s         = (phase_r == LAST_PHASE);
    phase_next_s    = phase_r + ONE_C;
    pulse_next_s    = pulse_seen_r | qual_s;
    all_high_next_s = all_high_r & rx_i;
    close_bit_s     = ~(pulse_seen_r | qual_s);
    close_err_s     = all_high_r & rx_i;

    if (close_s) begin
      phase_next_s    = ZERO_C;
      pulse_next_s    = 1'b0;
      all_high_next_s = 1'b1;
    end else begin
      phase_next_s = phase_r + ONE_C;
    end

`ifdef IRDA_RZ_RESYNC_EN
    edge_s = rx_i & ~rx_d_r;
    if (edge_s && close_s) begin
      // Early edge: close without this sample, which becomes phase 0 of the
      // next window. The previous sample was low, so err is necessarily 0.
      close_bit_s     = ~pulse_seen_r;
      close_err_s     = all_high_r & rx_d_r;
      phase_next_s    = ONE_C;
      pulse_next_s    = qual_s;
      all_high_next_s = 1'b1;
    end else if (edge_s && (phase_r == ONE_C)) begin
      // Late edge: repeat phase 1 once to stretch this window by a sample.
      phase_next_s = ONE_C;
    end else begin
      phase_next_s = phase_next_s;
    end
`endif
  end

  // Window state and registered outputs.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      phase_r      <= ZERO_C;
      run_r        <= ZERO_C;
      pulse_seen_r <= 1'b0;
      all_high_r   <= 1'b1;
      bit_o        <= 1'b0;
      bit_valid_o  <= 1'b0;
      err_o        <= 1'b0;
    end else if (!active_s) begin
      phase_r      <= ZERO_C;
      run_r        <= ZERO_C;
      pulse_seen_r <= 1'b0;
      all_high_r   <= 1'b1;
      bit_valid_o  <= 1'b0;
    end else begin
      phase_r      <= phase_next_s;
      run_r        <= run_next_s;
      pulse_seen_r <= pulse_next_s;
      all_high_r   <= all_high_next_s;
      bit_valid_o  <= close_s;
      if (close_s) begin
        bit_o <= close_bit_s;
        err_o <= close_err_s;
      end else begin
        bit_o <= bit_o;
        err_o <= err_o;
      end
    end
  end

`ifdef IRDA_RZ_RESYNC_EN
  // Previous active sample, used to find rising edges for phase re-alignment.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_d_r <= 1'b0;
    end else if (!active_s) begin
      rx_d_r <= 1'b0;
    end else begin
      rx_d_r <= rx_i;
    end
  end
`endif

endmodule

// File: tb/tb_irda_rz_bit_decoder.sv
// Directed bench for irda_rz_bit_decoder: dut_a (OSR=4, MIN_PULSE=1) runs a
// per-cycle vector table plus reset and phase-alignment sequences; dut_b
// (OSR=8, MIN_PULSE=2) checks glitch rejection.

module tb_irda_rz_bit_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic wb_rst_i, fast_enable, mir_mode;
  logic tx_select, rx_a, tx_select_b, rx_b;
  logic bit_a, valid_a, err_a;
  logic bit_b, valid_b, err_b;

  int checks = 0;
  int errors = 0;

  irda_rz_bit_decoder #(.OSR(4), .CNT_W(4), .MIN_PULSE(1)) dut_a (
    .clk(clk), .wb_rst_i(wb_rst_i), .fast_enable(fast_enable), .mir_mode(mir_mode),
    .tx_select(tx_select), .rx_i(rx_a),
    .bit_o(bit_a), .bit_valid_o(valid_a), .err_o(err_a)
  );

  irda_rz_bit_decoder #(.OSR(8), .CNT_W(4), .MIN_PULSE(2)) dut_b (
    .clk(clk), .wb_rst_i(wb_rst_i), .fast_enable(fast_enable), .mir_mode(mir_mode),
    .tx_select(tx_select_b), .rx_i(rx_b),
    .bit_o(bit_b), .bit_valid_o(valid_b), .err_o(err_b)
  );

  typedef struct {
    logic tx;
    logic rx;
    logic v;
    logic b;
    logic e;
  } vec_t;

  vec_t vecs[$];

  task automatic add_n(input int n, input logic tx, input logic rx,
                       input logic v, input logic b, input logic e);
    for (int k = 0; k < n; k++) vecs.push_back('{tx, rx, v, b, e});
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    logic ev, eb;

    // Per-cycle table for dut_a: {tx_select, rx, valid, bit, err}.
    // A strobe is visible right after the edge that samples phase 3.
    add_n(3,1'b0,1'b0,1'b0,1'b0,1'b0); add_n(1,1'b0,1'b0,1'b1,1'b1,1'b0); // c0-3  all low
    add_n(3,1'b0,1'b0,1'b0,1'b1,1'b0); add_n(1,1'b0,1'b0,1'b1,1'b1,1'b0); // c4-7  all low
    add_n(2,1'b0,1'b0,1'b0,1'b1,1'b0); add_n(1,1'b0,1'b1,1'b0,1'b1,1'b0); // c8-10 pulse phase 2
    add_n(1,1'b0,1'b0,1'b1,1'b0,1'b0);                                   // c11 bit 0
    add_n(3,1'b0,1'b0,1'b0,1'b0,1'b0); add_n(1,1'b0,1'b0,1'b1,1'b1,1'b0); // c12-15 all low
    add_n(3,1'b0,1'b1,1'b0,1'b1,1'b0); add_n(1,1'b0,1'b1,1'b1,1'b0,1'b1); // c16-19 all high
    // Run is saturated and does not re-qualify: no pulse in 2nd window, still err.
    add_n(3,1'b0,1'b1,1'b0,1'b0,1'b1); add_n(1,1'b0,1'b1,1'b1,1'b1,1'b1); // c20-23 all high
    add_n(3,1'b0,1'b0,1'b0,1'b1,1'b1); add_n(1,1'b0,1'b0,1'b1,1'b1,1'b0); // c24-27 low, err clears
    add_n(1,1'b0,1'b1,1'b0,1'b1,1'b0); add_n(2,1'b0,1'b0,1'b0,1'b1,1'b0); // c28-30 pulse phase 0
    add_n(1,1'b0,1'b0,1'b1,1'b0,1'b0);                                   // c31 bit 0
    add_n(2,1'b0,1'b0,1'b0,1'b0,1'b0);                                   // c32-33 phases 0,1
    add_n(1,1'b1,1'b0,1'b0,1'b0,1'b0); add_n(1,1'b1,1'b1,1'b0,1'b0,1'b0); // c34-35 idle, rx ignored
    add_n(3,1'b1,1'b0,1'b0,1'b0,1'b0);                                   // c36-38 idle
    add_n(3,1'b0,1'b0,1'b0,1'b0,1'b0); add_n(1,1'b0,1'b0,1'b1,1'b1,1'b0); // c39-42 fresh window

    wb_rst_i = 1'b1; fast_enable = 1'b1; mir_mode = 1'b1;
    tx_select = 1'b1; tx_select_b = 1'b1; rx_a = 1'b0; rx_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_bit", bit_a, 1'b0);
    check("reset_valid", valid_a, 1'b0);
    check("reset_err", err_a, 1'b0);
    @(negedge clk);
    wb_rst_i = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      tx_select = vecs[i].tx;
      rx_a      = vecs[i].rx;
      @(posedge clk);
      #1;
      check($sformatf("tbl_valid_c%0d", i), valid_a, vecs[i].v);
      check($sformatf("tbl_bit_c%0d", i), bit_a, vecs[i].b);
      check($sformatf("tbl_err_c%0d", i), err_a, vecs[i].e);
    end

    // Asynchronous reset mid-window clears held bit_o=1 without a clock edge.
    @(negedge clk);
    rx_a = 1'b0;
    @(posedge clk);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("async_rst_bit", bit_a, 1'b0);
    check("async_rst_valid", valid_a, 1'b0);
    check("async_rst_err", err_a, 1'b0);
    tx_select = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;

    // Single-sample pulse at phase 3 of the first window.
    for (int d = 0; d < 12; d++) begin
      @(negedge clk);
      tx_select = 1'b0;
      rx_a = (d == 3) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
`ifdef IRDA_RZ_RESYNC_EN
      ev = (d == 3) || (d == 6) || (d == 10);
      eb = (d != 6);
`else
      ev = ((d % 4) == 3);
      eb = (d != 3);
`endif
      check($sformatf("align_valid_d%0d", d), valid_a, ev);
      if (ev) begin
        check($sformatf("align_bit_d%0d", d), bit_a, eb);
        check($sformatf("align_err_d%0d", d), err_a, 1'b0);
      end
    end

    // dut_b: 1-sample glitch rejected, 2-sample pulse at phases 6-7 accepted.
    @(negedge clk);
    tx_select = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int p, w;
      p = k % 8;
      w = k / 8;
      @(negedge clk);
      tx_select_b = 1'b0;
      rx_b = ((w == 0) && (p == 3)) || ((w == 1) && (p >= 6));
      @(posedge clk);
      #1;
      check($sformatf("b_valid_k%0d", k), valid_b, (p == 7));
      if (p == 7) begin
        check($sformatf("b_bit_w%0d", w), bit_b, (w != 1));
        check($sformatf("b_err_w%0d", w), err_b, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
